// File: rtl/bus_timer.sv
// Memory-mapped down-counter timer on a shared tri-state CPU bus.
// Prescaled tick, one-shot or auto-reload expiry, sticky pending flag driving irq.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] data,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic        irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
  logic                 irq_en_q, irq_en_d;
  logic                 reload_en_q, reload_en_d;
  logic [31:0]          reload_q, reload_d;
  logic [31:0]          count_q, count_d;
  logic                 pending_q, pending_d;

  logic        hit;
  logic [1:0]  idx;
  logic [31:0] wr_data;
  logic        wr_ctrl, wr_reload, wr_count, wr_status;
  logic        tick, expiry;
  logic        rd_drive;
  logic [31:0] rdata;

  assign hit       = (addr[31:2] == BASE_ADDR[31:2]);
  assign idx       = addr[1:0];
  assign wr_data   = data;
  assign wr_ctrl   = wr && hit && (idx == REG_CTRL);
  assign wr_reload = wr && hit && (idx == REG_RELOAD);
  assign wr_count  = wr && hit && (idx == REG_COUNT);
  assign wr_status = wr && hit && (idx == REG_STATUS);

  assign tick   = (state_q == RUN) && (presc_cnt_q == presc_q);
  assign expiry = tick && (count_q == 32'd0);

  // State register.
  // NOTE: every register, including the wide COUNT/RELOAD words, is cleared by
  // reset so no expiry or stale irq can survive a reset taken mid-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic: a CTRL write overrides the one-shot auto-stop.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (wr_ctrl) begin
      state_d = wr_data[0] ? RUN : IDLE;
    end else if (expiry && !reload_en_q) begin
      state_d = IDLE;
    end
  end

  // Datapath next values.
  always_comb begin
    presc_d     = presc_q;
    irq_en_d    = irq_en_q;
    reload_en_d = reload_en_q;
    reload_d    = reload_q;
    count_d     = count_q;
    presc_cnt_d = presc_cnt_q;
    pending_d   = pending_q;

    if (wr_ctrl) begin
      presc_d     = wr_data[16 +: PRESC_W];
      irq_en_d    = wr_data[2];
      reload_en_d = wr_data[1];
    end
    if (wr_reload) begin
      reload_d = wr_data;
    end

    if (wr_ctrl && wr_data[0]) begin
      presc_cnt_d = '0;
    end else if (state_q == RUN) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    end

    if (wr_count) begin
      count_d = wr_data;
    end else if (expiry && reload_en_q) begin
      count_d = reload_q;
    end else if (tick && (count_q != 32'd0)) begin
      count_d = count_q - 32'd1;
    end

    // Expiry set is evaluated last so it wins over a same-cycle W1C.
    if (wr_status && wr_data[0]) begin
      pending_d = 1'b0;
    end
    if (expiry) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      irq_en_q    <= 1'b0;
      reload_en_q <= 1'b0;
      reload_q    <= '0;
      count_q     <= '0;
      presc_cnt_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      irq_en_q    <= irq_en_d;
      reload_en_q <= reload_en_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      presc_cnt_q <= presc_cnt_d;
      pending_q   <= pending_d;
    end
  end

  // Outputs: read mux, bus drive and irq, all from registered state.
  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_CTRL: begin
        rdata[16 +: PRESC_W] = presc_q;
        rdata[2]             = irq_en_q;
        rdata[1]             = reload_en_q;
        rdata[0]             = (state_q == RUN);
      end
      REG_RELOAD: rdata = reload_q;
      REG_COUNT:  rdata = count_q;
      REG_STATUS: rdata[0] = pending_q;
      default:    rdata = '0;
    endcase
  end

  assign rd_drive = rd && hit && !wr;
  assign data     = rd_drive ? rdata : 'z;
  assign irq      = pending_q && irq_en_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: reset, one-shot, auto-reload, collisions, decode.
// A pull-up on the bus makes an undriven bus read as all ones.
module tb_bus_timer;

  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic        irq;
  logic [31:0] cpu_data;
  logic        cpu_drive;
  wire  [31:0] data;
  logic [31:0] v;

  int errors = 0;
  int checks = 0;

  assign data = cpu_drive ? cpu_data : 'z;
  pullup pu_data (data);

  bus_timer #(.BASE_ADDR(32'h0000_4000), .PRESC_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .addr (addr),
    .rd   (rd),
    .wr   (wr),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; cpu_data = d; cpu_drive = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0; cpu_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1;
    d = data;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_write(BASE + 1, 32'd7);
    bus_write(BASE + 2, 32'd1);
    bus_write(BASE, 32'h0000_0007);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL reset_pre_irq: got %b want 1", irq);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    checks++;
    if (data !== FLOAT) begin
      errors++; $display("FAIL reset_bus_idle: got %h want %h", data, FLOAT);
    end
    for (int r = 0; r < 4; r++) begin
      bus_read(BASE + r, v);
      checks++;
      if (v !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h want 00000000", r, v);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    bus_read(BASE + 2, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_count_after: got %h want 00000000", v);
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] exp_c;
    bus_write(BASE + 2, 32'd3);
    bus_write(BASE, 32'h0000_0005);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (irq !== (i >= 4)) begin
        errors++; $display("FAIL oneshot_irq_c%0d: got %b want %b", i, irq, (i >= 4));
      end
      exp_c = (i < 3) ? 32'(3 - i) : 32'd0;
      bus_read(BASE + 2, v);
      checks++;
      if (v !== exp_c) begin
        errors++; $display("FAIL oneshot_count_c%0d: got %h want %h", i, v, exp_c);
      end
    end
    bus_read(BASE, v);
    checks++;
    if (v !== 32'h0000_0004) begin
      errors++; $display("FAIL oneshot_ctrl: got %h want 00000004", v);
    end
    bus_write(BASE + 3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL oneshot_w1c_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] exp_c;
    bus_write(BASE + 1, 32'd2);
    bus_write(BASE + 2, 32'd2);
    bus_write(BASE, 32'h0001_0007);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (irq !== (i >= 6)) begin
        errors++; $display("FAIL reload_irq_c%0d: got %b want %b", i, irq, (i >= 6));
      end
      exp_c = 32'(2 - ((i / 2) % 3));
      bus_read(BASE + 2, v);
      checks++;
      if (v !== exp_c) begin
        errors++; $display("FAIL reload_count_c%0d: got %h want %h", i, v, exp_c);
      end
    end
    bus_write(BASE + 3, 32'h1);
    for (int i = 9; i <= 12; i++) begin
      if (i > 9) @(posedge clk);
      #1;
      checks++;
      if (irq !== (i == 12)) begin
        errors++; $display("FAIL reload_irq_c%0d: got %b want %b", i, irq, (i == 12));
      end
      exp_c = 32'(2 - ((i / 2) % 3));
      bus_read(BASE + 2, v);
      checks++;
      if (v !== exp_c) begin
        errors++; $display("FAIL reload_count_c%0d: got %h want %h", i, v, exp_c);
      end
    end
    bus_write(BASE, 32'h0);
    bus_write(BASE + 3, 32'h1);
  endtask

  task automatic test_collisions();
    // COUNT write on a tick cycle keeps the written value.
    bus_write(BASE + 2, 32'd3);
    bus_write(BASE, 32'h0000_0001);
    bus_write(BASE + 2, 32'd10);
    bus_read(BASE + 2, v);
    checks++;
    if (v !== 32'd10) begin
      errors++; $display("FAIL coll_count_write: got %h want 0000000a", v);
    end
    bus_read(BASE + 2, v);
    checks++;
    if (v !== 32'd9) begin
      errors++; $display("FAIL coll_count_next: got %h want 00000009", v);
    end
    // CTRL write on the one-shot expiry cycle keeps en set.
    bus_write(BASE + 2, 32'd1);
    @(posedge clk);
    bus_write(BASE, 32'h0000_0001);
    bus_read(BASE, v);
    checks++;
    if (v !== 32'h0000_0001) begin
      errors++; $display("FAIL coll_ctrl_vs_expiry: got %h want 00000001", v);
    end
    bus_read(BASE + 3, v);
    checks++;
    if (v !== 32'h1) begin
      errors++; $display("FAIL coll_ctrl_pending: got %h want 00000001", v);
    end
    bus_write(BASE, 32'h0);
    bus_write(BASE + 3, 32'h1);
    // W1C landing on an expiry cycle loses to the set.
    bus_write(BASE + 2, 32'd1);
    bus_write(BASE, 32'h0000_0003);
    @(posedge clk);
    bus_write(BASE + 3, 32'h1);
    bus_read(BASE + 3, v);
    checks++;
    if (v !== 32'h1) begin
      errors++; $display("FAIL coll_w1c_vs_expiry: got %h want 00000001", v);
    end
    bus_write(BASE, 32'h0);
    bus_write(BASE + 3, 32'h1);
    // rd and wr together: a write, and the timer leaves the bus alone.
    @(negedge clk);
    addr = BASE + 1; cpu_data = 32'h5A5A_0F0F; cpu_drive = 1'b1; wr = 1'b1; rd = 1'b1;
    #1;
    checks++;
    if (data !== 32'h5A5A_0F0F) begin
      errors++; $display("FAIL coll_rdwr_bus: got %h want 5a5a0f0f", data);
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; cpu_drive = 1'b0;
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h5A5A_0F0F) begin
      errors++; $display("FAIL coll_rdwr_written: got %h want 5a5a0f0f", v);
    end
  endtask

  task automatic test_decode();
    bus_write(BASE + 1, 32'h1234_5678);
    bus_read(BASE + 1, v);
    checks++;
    if (v !== 32'h1234_5678) begin
      errors++; $display("FAIL dec_reload_read: got %h want 12345678", v);
    end
    bus_read(BASE + 4, v);
    checks++;
    if (v !== FLOAT) begin
      errors++; $display("FAIL dec_base_plus4: got %h want %h", v, FLOAT);
    end
    bus_read(BASE - 1, v);
    checks++;
    if (v !== FLOAT) begin
      errors++; $display("FAIL dec_base_minus1: got %h want %h", v, FLOAT);
    end
    bus_write(BASE + 2, 32'd0);
    bus_write(BASE, 32'h0000_0001);
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL dec_irq_masked: got %b want 0", irq);
    end
    bus_read(BASE + 3, v);
    checks++;
    if (v !== 32'h1) begin
      errors++; $display("FAIL dec_pending_set: got %h want 00000001", v);
    end
    bus_read(BASE, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL dec_oneshot_stop: got %h want 00000000", v);
    end
    bus_write(BASE, 32'h0000_0004);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL dec_irq_unmasked: got %b want 1", irq);
    end
  endtask

  initial begin
    rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; cpu_data = '0; cpu_drive = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_collisions();
    test_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
